ct_mmu_jtlb_rr_arb: RTL and testbench
=====================================

CT_MMU_JTLB_RR_ARB -- requirements
Module: ct_mmu_jtlb_rr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of uTLB/PFU refill requesters (2..8).
REQ-002 SHALL have parameter VPN_W, default 28, VPN width per requester.
REQ-003 SHALL have parameter STARVE_MAX, default 15, starvation threshold in cycles (1..255).
REQ-004 SHALL have port forever_cpuclk  input  1  sole clock, all flops on its rising edge.
REQ-005 SHALL have port cpurst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port refill_req  input  NUM_REQ  per-requester refill request, held until granted.
REQ-007 SHALL have port refill_vpn  input  NUM_REQ*VPN_W  packed VPNs; requester i at bits [i*VPN_W +: VPN_W].
REQ-008 SHALL have port refill_cmplt  input  NUM_REQ  per-requester completion pulse.
REQ-009 SHALL have port oper_req  input  1  TLB-maintenance request.
REQ-010 SHALL have port oper_vpn  input  VPN_W  maintenance VPN.
REQ-011 SHALL have port oper_cmplt  input  1  maintenance completion pulse.
REQ-012 SHALL have port ptw_req  input  1  page-walk refill write, single cycle.
REQ-013 SHALL have port ptw_vpn  input  VPN_W  page-walk VPN.
REQ-014 SHALL have port no_op_req  input  1  CP0 quiesce request.
REQ-015 SHALL have port refill_grant  output  NUM_REQ  one-hot refill grant.
REQ-016 SHALL have port oper_grant / ptw_grant  output  1 each  grants.
REQ-017 SHALL have port jtlb_req  output  1  OR of all grants.
REQ-018 SHALL have port jtlb_vpn  output  VPN_W  VPN of the granted source, 0 when none.
REQ-019 SHALL have port ptw_mask  output  1  high while state is OPER.
REQ-020 SHALL have port no_op  output  1  quiesce acknowledge.
REQ-021 SHALL have port cur_st  output  2  FSM state (debug).

Function
REQ-022 SHALL implement FSM IDLE=2'b00, REFILL=2'b01, OPER=2'b10; 2'b11 returns to IDLE.
REQ-023 SHALL assert ptw_grant = ptw_req combinationally in any state except OPER; ptw_grant does not change state.
REQ-024 SHALL, in IDLE with no ptw_req, grant oper_req over refill_req unless starve_hit is set.
REQ-025 SHALL, in IDLE with no ptw_req and no oper grant, grant the first asserted refill_req searching from rr_ptr upward, wrapping at NUM_REQ-1 to 0.
REQ-026 SHALL issue refill/oper grants only in IDLE, same cycle as request (zero latency), at most one grant per cycle including ptw.
REQ-027 SHALL, on refill grant to index i, go to REFILL, register owner=i, set rr_ptr=(i+1) mod NUM_REQ.
REQ-028 SHALL stay in REFILL until refill_cmplt[owner]; other requesters' cmplt bits are ignored.
REQ-029 SHALL, on oper grant, go to OPER and leave on oper_cmplt; oper_cmplt outside OPER is ignored.
REQ-030 SHALL return to IDLE the cycle after completion; new refill/oper grants are first possible in that IDLE cycle (one-cycle bubble).
REQ-031 SHALL keep 8-bit starve_cnt: in IDLE, increment (saturating at STARVE_MAX) each cycle oper is granted while any refill_req is pending; clear on any refill grant.
REQ-032 SHALL set starve_hit when starve_cnt==STARVE_MAX; while set, oper_req is not granted in IDLE.
REQ-033 SHALL drive no_op = no_op_req && cur_st!=REFILL.
REQ-034 SHALL select jtlb_vpn as AND-OR mux of granted source; grants are mutually exclusive.

Reset
REQ-035 SHALL, while cpurst high, force cur_st=IDLE, owner=0, rr_ptr=0, starve_cnt=0, regardless of clock.
REQ-036 SHALL drive all grants, jtlb_req, ptw_mask, jtlb_vpn to 0 during reset and after release with inputs low; no_op follows no_op_req.
REQ-037 SHALL, on reset mid-REFILL/OPER, abandon ownership; pending completions after release are ignored.

Verification
REQ-038 SHALL cover: NUM_REQ=4, refill_req=4'b1111 held, each cmplt returned 2 cycles after grant -> grant order 0,1,2,3,0 with one IDLE bubble between.
REQ-039 SHALL cover: REFILL owner=1, ptw_req pulse -> ptw_grant=1 that cycle, cur_st stays 2'b01, refill_grant=0.
REQ-040 SHALL cover: OPER active, ptw_req=1 -> ptw_grant=0, ptw_mask=1 until cycle after oper_cmplt.
REQ-041 SHALL cover: STARVE_MAX=3, oper_req and refill_req[2] held, oper_cmplt immediate -> oper granted 3 times, then refill_grant=4'b0100, starve_cnt=0.
REQ-042 SHALL cover: cpurst asserted in REFILL owner=3 -> cur_st=0, rr_ptr=0 immediately; refill_cmplt[3] after release no effect.
REQ-043 SHALL cover: no_op_req=1 in REFILL -> no_op=0; cycle after owner cmplt -> no_op=1.

Source files
------------

// File: rtl/ct_mmu_jtlb_rr_arb.sv
// ---------------------------------------------------------------------------
// ct_mmu_jtlb_rr_arb
// Decides which source may access the joint TLB (jTLB). There are three kinds
// of source:
//   - NUM_REQ uTLB/PFU refill requesters, served round-robin. A granted
//     refill owns the jTLB until that requester signals completion.
//   - One TLB-maintenance (oper) source. It wins over refills in IDLE unless
//     refills have been starved for STARVE_MAX oper grants in a row.
//   - The page-table walker refill write (ptw). It is a single-cycle write
//     that is granted in any state except OPER and never changes state.
// Ports:
//   forever_cpuclk / cpurst       clock, asynchronous active-high reset
//   refill_req/vpn/cmplt          per-requester request, VPN, completion
//   oper_req/vpn/cmplt            maintenance request, VPN, completion
//   ptw_req/vpn                   page-walk write request and VPN
//   no_op_req                     CP0 quiesce request
//   refill_grant/oper_grant/ptw_grant   one-hot grants (at most one set)
//   jtlb_req / jtlb_vpn           any-grant flag and VPN of the granted source
//   ptw_mask                      high while a maintenance op owns the jTLB
//   no_op                         quiesce acknowledge
//   cur_st                        arbiter state, for debug
// ---------------------------------------------------------------------------
module ct_mmu_jtlb_rr_arb #(
   parameter int NUM_REQ    = 4,
   parameter int VPN_W      = 28,
   parameter int STARVE_MAX = 15
) (
   input  logic                     forever_cpuclk,
   input  logic                     cpurst,
   input  logic [NUM_REQ-1:0]       refill_req,
   input  logic [NUM_REQ*VPN_W-1:0] refill_vpn,
   input  logic [NUM_REQ-1:0]       refill_cmplt,
   input  logic                     oper_req,
   input  logic [VPN_W-1:0]         oper_vpn,
   input  logic                     oper_cmplt,
   input  logic                     ptw_req,
   input  logic [VPN_W-1:0]         ptw_vpn,
   input  logic                     no_op_req,
   output logic [NUM_REQ-1:0]       refill_grant,
   output logic                     oper_grant,
   output logic                     ptw_grant,
   output logic                     jtlb_req,
   output logic [VPN_W-1:0]         jtlb_vpn,
   output logic                     ptw_mask,
   output logic                     no_op,
   output logic [1:0]               cur_st
);

   localparam int         IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_REFILL = 2'b01,
      ST_OPER   = 2'b10,
      ST_RSVD   = 2'b11
   } arb_state_e;

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [7:0]       starve_cnt_q, starve_cnt_d;
   logic             starve_hit;
   logic             refill_win;
   logic [IDX_W-1:0] win_idx;

   assign starve_hit = (starve_cnt_q == STARVE_LIM);

   // Round-robin search: walk the requesters starting at rr_ptr and wrap
   // back to 0 past the last one; the first asserted request wins. The
   // search result is only used when the arbiter is IDLE and nothing with
   // higher priority is being granted.
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      refill_win = 1'b0;
      win_idx    = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(rr_ptr_q) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IDX_W'(cand);
         if (!refill_win && refill_req[cand_idx]) begin
            refill_win = 1'b1;
            win_idx    = cand_idx;
         end
      end
   end

   // Grant selection. The page-walk write always goes first outside OPER, so
   // a refill or oper grant only happens in an IDLE cycle without ptw_req.
   // Oper beats refill unless the starvation counter has saturated. All
   // grants are held low while reset is asserted.
   always_comb begin
      refill_grant = '0;
      oper_grant   = 1'b0;
      ptw_grant    = 1'b0;
      if (!cpurst) begin
         if (ptw_req && (state_q != ST_OPER)) begin
            ptw_grant = 1'b1;
         end else if (state_q == ST_IDLE) begin
            if (oper_req && !starve_hit) begin
               oper_grant = 1'b1;
            end else if (refill_win) begin
               refill_grant[win_idx] = 1'b1;
            end
         end
      end
   end

   // Next-state logic. A refill grant records the owner and moves the
   // round-robin pointer just past it; only that owner's completion ends the
   // REFILL phase. The starvation counter counts oper grants taken while a
   // refill was waiting and is cleared whenever a refill finally wins.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      rr_ptr_d     = rr_ptr_q;
      starve_cnt_d = starve_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (|refill_grant) begin
               state_d      = ST_REFILL;
               owner_d      = win_idx;
               rr_ptr_d     = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + IDX_W'(1);
               starve_cnt_d = '0;
            end else if (oper_grant) begin
               state_d = ST_OPER;
               if ((|refill_req) && (starve_cnt_q < STARVE_LIM)) begin
                  starve_cnt_d = starve_cnt_q + 8'd1;
               end
            end
         end
         ST_REFILL: begin
            if (refill_cmplt[owner_q]) begin
               state_d = ST_IDLE;
            end
         end
         ST_OPER: begin
            if (oper_cmplt) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers. Reset drops any ownership immediately, so a completion
   // arriving after reset release finds the arbiter in IDLE and is ignored.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         state_q      <= ST_IDLE;
         owner_q      <= '0;
         rr_ptr_q     <= '0;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         rr_ptr_q     <= rr_ptr_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // jTLB address mux. Grants are one-hot, so a plain AND-OR picks the VPN
   // of the granted source and yields zero when nothing is granted.
   always_comb begin
      jtlb_vpn = ({VPN_W{oper_grant}} & oper_vpn) | ({VPN_W{ptw_grant}} & ptw_vpn);
      for (int i = 0; i < NUM_REQ; i++) begin
         jtlb_vpn = jtlb_vpn | ({VPN_W{refill_grant[i]}} & refill_vpn[i*VPN_W +: VPN_W]);
      end
   end

   // Status outputs. A quiesce is acknowledged whenever no refill owns the
   // jTLB.
   assign jtlb_req = (|refill_grant) | oper_grant | ptw_grant;
   assign ptw_mask = (state_q == ST_OPER);
   assign no_op    = no_op_req && (state_q != ST_REFILL);
   assign cur_st   = state_q;

endmodule

// File: tb/tb_ct_mmu_jtlb_rr_arb.sv
// ---------------------------------------------------------------------------
// tb_ct_mmu_jtlb_rr_arb
// Bench for the jTLB arbiter. It keeps a behavioural model of the arbiter
// (busy kind, owner, round-robin pointer, starvation count) and compares
// every output against it on every cycle. It also runs directed scenarios
// whose outcomes are pinned to hand-computed constants, followed by a
// randomized run.
// ---------------------------------------------------------------------------
module tb_ct_mmu_jtlb_rr_arb;

   localparam int NUM_REQ    = 4;
   localparam int VPN_W      = 28;
   localparam int STARVE_MAX = 3;

   logic                     forever_cpuclk = 1'b0;
   logic                     cpurst;
   logic [NUM_REQ-1:0]       refill_req;
   logic [NUM_REQ*VPN_W-1:0] refill_vpn;
   logic [NUM_REQ-1:0]       refill_cmplt;
   logic                     oper_req;
   logic [VPN_W-1:0]         oper_vpn;
   logic                     oper_cmplt;
   logic                     ptw_req;
   logic [VPN_W-1:0]         ptw_vpn;
   logic                     no_op_req;
   logic [NUM_REQ-1:0]       refill_grant;
   logic                     oper_grant;
   logic                     ptw_grant;
   logic                     jtlb_req;
   logic [VPN_W-1:0]         jtlb_vpn;
   logic                     ptw_mask;
   logic                     no_op;
   logic [1:0]               cur_st;

   ct_mmu_jtlb_rr_arb #(
      .NUM_REQ    (NUM_REQ),
      .VPN_W      (VPN_W),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .forever_cpuclk (forever_cpuclk),
      .cpurst         (cpurst),
      .refill_req     (refill_req),
      .refill_vpn     (refill_vpn),
      .refill_cmplt   (refill_cmplt),
      .oper_req       (oper_req),
      .oper_vpn       (oper_vpn),
      .oper_cmplt     (oper_cmplt),
      .ptw_req        (ptw_req),
      .ptw_vpn        (ptw_vpn),
      .no_op_req      (no_op_req),
      .refill_grant   (refill_grant),
      .oper_grant     (oper_grant),
      .ptw_grant      (ptw_grant),
      .jtlb_req       (jtlb_req),
      .jtlb_vpn       (jtlb_vpn),
      .ptw_mask       (ptw_mask),
      .no_op          (no_op),
      .cur_st         (cur_st)
   );

   // 10-unit clock period.
   always #5 forever_cpuclk = ~forever_cpuclk;

   // Model state: m_busy is 0 when free, 1 while a refill owns the jTLB,
   // 2 while a maintenance op owns it.
   int m_busy;
   int m_owner;
   int m_next;
   int m_starve;

   logic [NUM_REQ-1:0] exp_refill_grant;
   logic               exp_oper_grant;
   logic               exp_ptw_grant;
   logic               exp_jtlb_req;
   logic [VPN_W-1:0]   exp_jtlb_vpn;
   logic               exp_ptw_mask;
   logic               exp_no_op;
   logic [1:0]         exp_cur_st;

   logic [NUM_REQ-1:0] act_refill_grant;
   logic               act_oper_grant;
   logic               act_ptw_grant;
   logic               act_jtlb_req;
   logic [VPN_W-1:0]   act_jtlb_vpn;
   logic               act_ptw_mask;
   logic               act_no_op;
   logic [1:0]         act_cur_st;

   int num_compared   = 0;
   int num_mismatched = 0;
   int cycle_cnt      = 0;

   function automatic void modelReset();
      m_busy   = 0;
      m_owner  = 0;
      m_next   = 0;
      m_starve = 0;
   endfunction

   // What the outputs must be this cycle, from the current model state and
   // the inputs being driven.
   function automatic void modelEval();
      exp_refill_grant = '0;
      exp_oper_grant   = 1'b0;
      exp_ptw_grant    = 1'b0;
      exp_jtlb_vpn     = '0;
      if (cpurst) begin
         modelReset();
      end
      exp_cur_st   = 2'(m_busy);
      exp_ptw_mask = (m_busy == 2);
      exp_no_op    = no_op_req && (m_busy != 1);
      if (!cpurst) begin
         if (ptw_req && m_busy != 2) begin
            exp_ptw_grant = 1'b1;
         end else if (m_busy == 0) begin
            if (oper_req && m_starve < STARVE_MAX) begin
               exp_oper_grant = 1'b1;
            end else begin
               for (int k = 0; k < NUM_REQ; k++) begin
                  int idx;
                  idx = (m_next + k) % NUM_REQ;
                  if (exp_refill_grant == '0 && refill_req[idx]) begin
                     exp_refill_grant[idx] = 1'b1;
                  end
               end
            end
         end
      end
      if (exp_oper_grant) exp_jtlb_vpn = oper_vpn;
      if (exp_ptw_grant)  exp_jtlb_vpn = ptw_vpn;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (exp_refill_grant[i]) exp_jtlb_vpn = refill_vpn[i*VPN_W +: VPN_W];
      end
      exp_jtlb_req = (exp_refill_grant != '0) || exp_oper_grant || exp_ptw_grant;
   endfunction

   // Advance the model across the clock edge.
   function automatic void modelClock();
      if (cpurst) begin
         modelReset();
      end else if (m_busy == 0) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (exp_refill_grant[i]) begin
               m_busy   = 1;
               m_owner  = i;
               m_next   = (i + 1) % NUM_REQ;
               m_starve = 0;
            end
         end
         if (exp_oper_grant) begin
            m_busy = 2;
            if (refill_req != '0 && m_starve < STARVE_MAX) m_starve = m_starve + 1;
         end
      end else if (m_busy == 1) begin
         if (refill_cmplt[m_owner]) m_busy = 0;
      end else begin
         if (oper_cmplt) m_busy = 0;
      end
   endfunction

   task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
      num_compared++;
      if (act !== exp) begin
         num_mismatched++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle_cnt, act, exp);
      end
   endtask

   // Sample every DUT output and hold it against the model's expectation.
   task automatic checkOutput();
      act_refill_grant = refill_grant;
      act_oper_grant   = oper_grant;
      act_ptw_grant    = ptw_grant;
      act_jtlb_req     = jtlb_req;
      act_jtlb_vpn     = jtlb_vpn;
      act_ptw_mask     = ptw_mask;
      act_no_op        = no_op;
      act_cur_st       = cur_st;
      checkField("refill_grant", 32'(act_refill_grant), 32'(exp_refill_grant));
      checkField("oper_grant",   32'(act_oper_grant),   32'(exp_oper_grant));
      checkField("ptw_grant",    32'(act_ptw_grant),    32'(exp_ptw_grant));
      checkField("jtlb_req",     32'(act_jtlb_req),     32'(exp_jtlb_req));
      checkField("jtlb_vpn",     32'(act_jtlb_vpn),     32'(exp_jtlb_vpn));
      checkField("ptw_mask",     32'(act_ptw_mask),     32'(exp_ptw_mask));
      checkField("no_op",        32'(act_no_op),        32'(exp_no_op));
      checkField("cur_st",       32'(act_cur_st),       32'(exp_cur_st));
   endtask

   // One clock cycle: inputs are already driven (just after the rising
   // edge); outputs are sampled on the falling edge.
   task automatic stepCycle();
      modelEval();
      @(negedge forever_cpuclk);
      checkOutput();
      modelClock();
      @(posedge forever_cpuclk);
      #1;
      cycle_cnt++;
   endtask

   task automatic clearInputs();
      refill_req   = '0;
      refill_cmplt = '0;
      oper_req     = 1'b0;
      oper_cmplt   = 1'b0;
      ptw_req      = 1'b0;
      no_op_req    = 1'b0;
   endtask

   // Random stimulus: requests are raised at random and held until granted,
   // completions and page-walk writes pulse at random, and an occasional
   // reset is thrown in.
   task automatic applyStimulus();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!refill_req[i] && $urandom_range(3) == 0) refill_req[i] = 1'b1;
         refill_cmplt[i] = ($urandom_range(2) == 0);
         refill_vpn[i*VPN_W +: VPN_W] = VPN_W'($urandom);
      end
      if (!oper_req && $urandom_range(3) == 0) oper_req = 1'b1;
      oper_cmplt = ($urandom_range(2) == 0);
      ptw_req    = ($urandom_range(5) == 0);
      no_op_req  = ($urandom_range(1) == 1);
      oper_vpn   = VPN_W'($urandom);
      ptw_vpn    = VPN_W'($urandom);
      cpurst     = ($urandom_range(199) == 0);
   endtask

   initial begin
      cpurst = 1'b1;
      clearInputs();
      refill_vpn = '0;
      for (int i = 0; i < NUM_REQ; i++) refill_vpn[i*VPN_W +: VPN_W] = VPN_W'(28'h1000 + i);
      oper_vpn = 28'h0ABCDEF;
      ptw_vpn  = 28'h0123456;
      modelReset();
      @(posedge forever_cpuclk);
      #1;

      // Reset: grants forced low even with ptw_req high, no_op follows request.
      ptw_req   = 1'b1;
      no_op_req = 1'b1;
      stepCycle();
      checkField("rst_ptw_grant", 32'(act_ptw_grant), 32'd0);
      checkField("rst_no_op",     32'(act_no_op),     32'd1);
      cpurst = 1'b0;
      clearInputs();
      stepCycle();
      checkField("post_rst_jtlb_req", 32'(act_jtlb_req), 32'd0);
      checkField("post_rst_cur_st",   32'(act_cur_st),   32'd0);

      // All requesters held, each completes two cycles after its grant:
      // grant order 0,1,2,3,0 with a free cycle in between.
      refill_req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         stepCycle();
         checkField("rr_order", 32'(act_refill_grant), 32'(4'b0001 << (g % 4)));
         checkField("rr_vpn",   32'(act_jtlb_vpn),     32'(28'h1000 + (g % 4)));
         stepCycle();
         checkField("rr_busy",  32'(act_cur_st),       32'd1);
         refill_cmplt = 4'(1 << (g % 4));
         stepCycle();
         refill_cmplt = '0;
      end
      refill_req = '0;

      // Refill owned by requester 1; a page-walk write still gets through.
      refill_req = 4'b0010;
      stepCycle();
      checkField("own1_grant", 32'(act_refill_grant), 32'h2);
      refill_req = '0;
      ptw_req    = 1'b1;
      stepCycle();
      checkField("ptw_in_refill",    32'(act_ptw_grant),    32'd1);
      checkField("ptw_refill_state", 32'(act_cur_st),       32'd1);
      checkField("ptw_refill_rg",    32'(act_refill_grant), 32'd0);
      ptw_req = 1'b0;

      // Quiesce is held off while a refill owns the jTLB.
      no_op_req = 1'b1;
      stepCycle();
      checkField("no_op_in_refill", 32'(act_no_op), 32'd0);
      refill_cmplt = 4'b1000;
      stepCycle();
      refill_cmplt = 4'b0010;
      stepCycle();
      refill_cmplt = '0;
      stepCycle();
      checkField("no_op_after_cmplt", 32'(act_no_op), 32'd1);
      no_op_req = 1'b0;

      // Maintenance op masks page-walk writes until it completes.
      oper_req = 1'b1;
      stepCycle();
      checkField("oper_grant", 32'(act_oper_grant), 32'd1);
      checkField("oper_vpn",   32'(act_jtlb_vpn),   32'h0ABCDEF);
      oper_req = 1'b0;
      ptw_req  = 1'b1;
      stepCycle();
      checkField("ptw_in_oper",  32'(act_ptw_grant), 32'd0);
      checkField("mask_in_oper", 32'(act_ptw_mask),  32'd1);
      oper_cmplt = 1'b1;
      stepCycle();
      checkField("mask_cmplt_cycle", 32'(act_ptw_mask), 32'd1);
      oper_cmplt = 1'b0;
      stepCycle();
      checkField("mask_after_oper", 32'(act_ptw_mask),  32'd0);
      checkField("ptw_after_oper",  32'(act_ptw_grant), 32'd1);
      ptw_req = 1'b0;

      // Starvation: oper wins three times, then the waiting refill wins.
      oper_req   = 1'b1;
      refill_req = 4'b0100;
      for (int n = 0; n < 3; n++) begin
         stepCycle();
         checkField("starve_oper_win", 32'(act_oper_grant), 32'd1);
         oper_cmplt = 1'b1;
         stepCycle();
         oper_cmplt = 1'b0;
      end
      stepCycle();
      checkField("starve_refill_win", 32'(act_refill_grant), 32'h4);
      checkField("starve_oper_held",  32'(act_oper_grant),   32'd0);
      refill_req   = '0;
      refill_cmplt = 4'b0100;
      stepCycle();
      refill_cmplt = '0;
      stepCycle();
      checkField("starve_cleared", 32'(act_oper_grant), 32'd1);
      oper_req   = 1'b0;
      oper_cmplt = 1'b1;
      stepCycle();
      oper_cmplt = 1'b0;

      // Reset in the middle of a refill owned by requester 3.
      refill_req = 4'b1000;
      stepCycle();
      checkField("own3_grant", 32'(act_refill_grant), 32'h8);
      refill_req = '0;
      stepCycle();
      cpurst = 1'b1;
      stepCycle();
      checkField("rst_mid_state", 32'(act_cur_st), 32'd0);
      cpurst       = 1'b0;
      refill_cmplt = 4'b1000;
      stepCycle();
      checkField("stale_cmplt", 32'(act_cur_st), 32'd0);
      refill_cmplt = '0;
      refill_req   = 4'b1110;
      stepCycle();
      checkField("ptr_after_rst", 32'(act_refill_grant), 32'h2);
      refill_req   = '0;
      refill_cmplt = 4'b0010;
      stepCycle();
      refill_cmplt = '0;
      stepCycle();

      // Randomized run against the model.
      for (int c = 0; c < 3000; c++) begin
         applyStimulus();
         stepCycle();
         refill_req = refill_req & ~exp_refill_grant;
         if (exp_oper_grant) oper_req = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
      $finish;
   end

endmodule
